// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and default widths for the spike rate decoder
package lif_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int WINDOW_W_DEF = 8;
   localparam int COUNT_W_DEF  = 8;

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// rtl/spike_rate_decoder_sat_counter.sv - saturating up-counter with sticky saturate flag
// Next-value outputs include this cycle's increment so the owner can capture a final count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_nxt_o,
   output logic         sat_nxt_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         sat_q, sat_d;

   always_comb begin
      cnt_nxt_o = cnt_q;
      sat_nxt_o = sat_q;
      if (inc_i) begin
         if (&cnt_q) begin
            sat_nxt_o = 1'b1;
         end else begin
            cnt_nxt_o = cnt_q + 1'b1;
         end
      end
      // clear wins for the stored value, but the caller still sees the incremented result
      cnt_d = clr_i ? '0 : cnt_nxt_o;
      sat_d = clr_i ? 1'b0 : sat_nxt_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - counts neuron spikes over a programmable step window
// ISI_EN adds isi_out/isi_valid: steps between consecutive spikes
module spike_rate_decoder
   import lif_pkg::*;
#(
   parameter int WINDOW_W = WINDOW_W_DEF,
   parameter int COUNT_W  = COUNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                clear,
   input  logic                step,
   input  logic                spike,
   input  logic [WINDOW_W-1:0] window_len,
   output logic [COUNT_W-1:0]  count_out,
   output logic                count_valid,
   output logic                saturated,
   output logic                busy
`ifdef ISI_EN
   ,
   output logic [WINDOW_W-1:0] isi_out,
   output logic                isi_valid
`endif
);

   state_e              state_q, state_d;
   logic [WINDOW_W-1:0] len_q, len_d;
   logic [WINDOW_W-1:0] step_cnt_q, step_cnt_d, step_nxt;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                sat_q, sat_d;
   logic                valid_q, valid_d;
   logic                running, step_run, last_step, win_clr;
   logic [COUNT_W-1:0]  spk_nxt;
   logic                spk_sat_nxt;

   assign running  = (state_q == RUN) && enable && !clear;
   assign step_run = running && step;
   // len_q of 0 wraps naturally: the full 2^WINDOW_W steps elapse before step_nxt returns to 0
   assign step_nxt  = step_cnt_q + 1'b1;
   assign last_step = step_run && (step_nxt == len_q);
   assign win_clr   = (state_q == IDLE) || last_step;

   sat_counter #(.W(COUNT_W)) u_spike_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (win_clr),
      .inc_i     (step_run && spike),
      .cnt_nxt_o (spk_nxt),
      .sat_nxt_o (spk_sat_nxt)
   );

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      step_cnt_d = step_cnt_q;
      count_d    = count_q;
      sat_d      = sat_q;
      valid_d    = 1'b0;
      case (state_q)
         IDLE: begin
            step_cnt_d = '0;
            if (enable && !clear) begin
               state_d = RUN;
               len_d   = window_len;
            end
         end
         RUN: begin
            if (!running) begin
               state_d = IDLE;
            end else if (last_step) begin
               step_cnt_d = '0;
               len_d      = window_len;
               count_d    = spk_nxt;
               sat_d      = spk_sat_nxt;
               valid_d    = 1'b1;
            end else if (step) begin
               step_cnt_d = step_nxt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         step_cnt_q <= '0;
         count_q    <= '0;
         sat_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         step_cnt_q <= step_cnt_d;
         count_q    <= count_d;
         sat_q      <= sat_d;
         valid_q    <= valid_d;
      end
   end

   assign count_out   = count_q;
   assign count_valid = valid_q;
   assign saturated   = sat_q;
   assign busy        = (state_q == RUN);

`ifdef ISI_EN
   logic                have_q, have_d;
   logic [WINDOW_W-1:0] isi_q, isi_d, isi_nxt;
   logic                isi_sat, isi_valid_q, isi_valid_d, spike_run;

   assign spike_run = step_run && spike;

   // interval = steps since last spike including this one; runs across window boundaries
   sat_counter #(.W(WINDOW_W)) u_isi_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     ((state_q == IDLE) || spike_run),
      .inc_i     (step_run),
      .cnt_nxt_o (isi_nxt),
      .sat_nxt_o (isi_sat)
   );

   always_comb begin
      have_d      = have_q;
      isi_d       = isi_q;
      isi_valid_d = 1'b0;
      if (state_q == IDLE) begin
         have_d = 1'b0;
         isi_d  = '0;
      end else if (spike_run) begin
         have_d = 1'b1;
         if (have_q) begin
            isi_d       = isi_sat ? '1 : isi_nxt;
            isi_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_q      <= 1'b0;
         isi_q       <= '0;
         isi_valid_q <= 1'b0;
      end else begin
         have_q      <= have_d;
         isi_q       <= isi_d;
         isi_valid_q <= isi_valid_d;
      end
   end

   assign isi_out   = isi_q;
   assign isi_valid = isi_valid_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - self-checking bench for spike_rate_decoder (ISI_EN aware)
module tb_spike_rate_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       clear;
   logic       step;
   logic       spike;
   logic [7:0] window_len;
   logic [7:0] count_out;
   logic       count_valid;
   logic       saturated;
   logic       busy;
`ifdef ISI_EN
   logic [7:0] isi_out;
   logic       isi_valid;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: window bookkeeping as plain integers
   bit m_run;
   int m_len, m_steps, m_spikes, m_count;
   bit m_sat, m_valid;
   bit m_have;
   int m_since, m_isi;
   bit m_isi_valid;

   spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .clear       (clear),
      .step        (step),
      .spike       (spike),
      .window_len  (window_len),
      .count_out   (count_out),
      .count_valid (count_valid),
      .saturated   (saturated),
      .busy        (busy)
`ifdef ISI_EN
      ,
      .isi_out     (isi_out),
      .isi_valid   (isi_valid)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_run = 0; m_len = 0; m_steps = 0; m_spikes = 0; m_count = 0;
      m_sat = 0; m_valid = 0; m_have = 0; m_since = 0; m_isi = 0; m_isi_valid = 0;
   endtask

   task automatic model_step();
      m_valid     = 0;
      m_isi_valid = 0;
      if (!m_run) begin
         m_have = 0; m_since = 0; m_isi = 0;
         if (enable && !clear) begin
            m_run    = 1;
            m_len    = (window_len == 0) ? 256 : int'(window_len);
            m_steps  = 0;
            m_spikes = 0;
         end
      end else if (!enable || clear) begin
         m_run = 0;
      end else if (step) begin
         m_steps++;
         m_since++;
         if (spike) begin
            m_spikes++;
            if (m_have) begin
               m_isi       = (m_since > 255) ? 255 : m_since;
               m_isi_valid = 1;
            end
            m_have  = 1;
            m_since = 0;
         end
         if (m_steps == m_len) begin
            m_count  = (m_spikes > 255) ? 255 : m_spikes;
            m_sat    = (m_spikes > 255);
            m_valid  = 1;
            m_steps  = 0;
            m_spikes = 0;
            m_len    = (window_len == 0) ? 256 : int'(window_len);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 0; enable = 0; clear = 0; step = 0; spike = 0; window_len = 8'd0;
      model_reset();
      #12;
      total++; if (count_out !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_out); end
      total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", count_valid); end
      total++; if (saturated !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", saturated); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      @(negedge clk);
      rst_n = 1;
      tick();
      tick();
      total++; if ({busy, count_valid} !== 2'b00) begin bad++; $display("FAIL reset_idle got=%b want=00", {busy, count_valid}); end
   endtask

   task automatic test_basic_window();
      int pat1[4] = '{1, 0, 1, 1};
      int pat2[4] = '{1, 1, 0, 0};
      window_len = 8'd4; enable = 1;
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
      for (int k = 0; k < 4; k++) begin
         step = 1; spike = pat1[k][0];
         tick();
         total++;
         if (count_valid !== (k == 3)) begin bad++; $display("FAIL basic_valid step=%0d got=%b want=%b", k + 1, count_valid, (k == 3)); end
      end
      total++; if (count_out !== 8'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", count_out); end
      total++; if (saturated !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b want=0", saturated); end
      for (int k = 0; k < 4; k++) begin
         step = 1; spike = pat2[k][0];
         tick();
         if (k == 0) begin
            total++; if ({count_valid, count_out} !== {1'b0, 8'd3}) begin bad++; $display("FAIL b2b_hold got=%b/%0d want=0/3", count_valid, count_out); end
         end
      end
      total++; if ({count_valid, count_out} !== {1'b1, 8'd2}) begin bad++; $display("FAIL b2b_count got=%b/%0d want=1/2", count_valid, count_out); end
      step = 0; spike = 1;
      tick();
      total++; if ({busy, count_valid, count_out} !== {1'b1, 1'b0, 8'd2}) begin bad++; $display("FAIL b2b_after got=%b%b/%0d want=10/2", busy, count_valid, count_out); end
   endtask

   task automatic test_saturate();
      enable = 0; step = 0; spike = 0;
      tick();
      window_len = 8'd0; enable = 1;
      tick();
      step = 1; spike = 1;
      for (int k = 0; k < 256; k++) begin
         tick();
         if (k == 254) begin
            total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL sat_early got=%b want=0", count_valid); end
         end
      end
      total++; if ({count_valid, saturated, count_out} !== {1'b1, 1'b1, 8'd255}) begin bad++; $display("FAIL sat_result got=%b%b/%0d want=11/255", count_valid, saturated, count_out); end
      step = 0;
      tick();
      total++; if ({count_valid, count_out} !== {1'b0, 8'd255}) begin bad++; $display("FAIL sat_pulse got=%b/%0d want=0/255", count_valid, count_out); end
   endtask

   task automatic test_abort();
      enable = 0; step = 0;
      tick();
      window_len = 8'd5; enable = 1;
      tick();
      step = 1; spike = 1;
      repeat (3) tick();
      step = 0; enable = 0;
      tick();
      total++; if ({busy, count_valid, saturated, count_out} !== {1'b0, 1'b0, 1'b1, 8'd255}) begin bad++; $display("FAIL abort_en got=%b%b%b/%0d want=001/255", busy, count_valid, saturated, count_out); end
      tick();
      total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL abort_en_late got=%b want=0", count_valid); end
      enable = 1;
      tick();
      step = 1; spike = 1;
      repeat (4) tick();
      clear = 1;
      tick();
      total++; if ({busy, count_valid, count_out} !== {1'b0, 1'b0, 8'd255}) begin bad++; $display("FAIL abort_clr got=%b%b/%0d want=00/255", busy, count_valid, count_out); end
      clear = 0; enable = 0; step = 0;
      tick();
      total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL abort_clr_late got=%b want=0", count_valid); end
   endtask

   task automatic test_len_change();
      enable = 0; step = 0;
      tick();
      window_len = 8'd4; enable = 1;
      tick();
      step = 1; spike = 1;
      tick();
      window_len = 8'd2;
      tick();
      tick();
      total++; if (count_valid !== 1'b0) begin bad++; $display("FAIL len_early got=%b want=0", count_valid); end
      tick();
      total++; if ({count_valid, count_out} !== {1'b1, 8'd4}) begin bad++; $display("FAIL len_first got=%b/%0d want=1/4", count_valid, count_out); end
      spike = 1;
      tick();
      spike = 0;
      tick();
      total++; if ({count_valid, count_out} !== {1'b1, 8'd1}) begin bad++; $display("FAIL len_second got=%b/%0d want=1/1", count_valid, count_out); end
      step = 0;
      tick();
   endtask

`ifdef ISI_EN
   task automatic test_isi();
      bit want_v;
      enable = 0; step = 0;
      tick();
      window_len = 8'd4; enable = 1;
      tick();
      for (int s = 1; s <= 12; s++) begin
         step = 1; spike = (s == 2 || s == 7 || s == 10);
         tick();
         want_v = (s == 7 || s == 10);
         total++; if (isi_valid !== want_v) begin bad++; $display("FAIL isi_valid step=%0d got=%b want=%b", s, isi_valid, want_v); end
         if (want_v) begin
            total++;
            if (isi_out !== ((s == 7) ? 8'd5 : 8'd3)) begin bad++; $display("FAIL isi_out step=%0d got=%0d want=%0d", s, isi_out, (s == 7) ? 5 : 3); end
         end
      end
      step = 0;
      tick();
   endtask
`endif

   task automatic test_random();
      logic [10:0] got, exp;
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 59) != 0);
         clear  = ($urandom_range(0, 99) == 0);
         step   = $urandom_range(0, 2) != 0;
         spike  = $urandom_range(0, 2) == 0;
         if ($urandom_range(0, 9) == 0)
            window_len = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 7));
         tick();
         got = {count_out, count_valid, saturated, busy};
         exp = {8'(m_count), m_valid, m_sat, m_run};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL rand cyc=%0d got cnt=%0d v=%b s=%b b=%b want cnt=%0d v=%b s=%b b=%b",
                     i, count_out, count_valid, saturated, busy, m_count, m_valid, m_sat, m_run);
         end
`ifdef ISI_EN
         total++;
         if ({isi_valid, isi_out} !== {m_isi_valid, 8'(m_isi)}) begin
            bad++;
            $display("FAIL rand_isi cyc=%0d got v=%b isi=%0d want v=%b isi=%0d", i, isi_valid, isi_out, m_isi_valid, m_isi);
         end
`endif
      end
      clear = 0;
   endtask

   task automatic test_async_reset();
      enable = 0; step = 0; clear = 0;
      tick();
      window_len = 8'd2; enable = 1;
      tick();
      step = 1; spike = 1;
      tick();
      tick();
      tick();
      total++; if ({busy, count_out} !== {1'b1, 8'd2}) begin bad++; $display("FAIL areset_pre got=%b/%0d want=1/2", busy, count_out); end
      #3;
      rst_n = 0;
      model_reset();
      #1;
      total++; if ({count_out, count_valid, saturated, busy} !== 11'd0) begin bad++; $display("FAIL areset_now got=%0d/%b%b%b want=0/000", count_out, count_valid, saturated, busy); end
      enable = 0; step = 0;
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         total++; if ({busy, count_valid} !== 2'b00) begin bad++; $display("FAIL areset_after cyc=%0d got=%b want=00", k, {busy, count_valid}); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_window();
      test_saturate();
      test_abort();
      test_len_change();
`ifdef ISI_EN
      test_isi();
`endif
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Downstream stage of the LIF neuron.
- Consumes the neuron's 1-bit spike output once per membrane update step and counts spikes over a programmable window of N steps.
- Emits the window's spike count as a rate code, with a one-cycle valid pulse and a saturation flag.
- Feeds the output pins / host readback, so a network output is read as a number instead of a raw spike train.

Parameters:
- WINDOW_W, 8, width of window-length field and step counter (max window 2^WINDOW_W steps)
- COUNT_W, 8, width of spike count output (saturating)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run decoding; low forces IDLE
- clear  in  1  synchronous abort of current window, return to IDLE
- step  in  1  one-cycle strobe: neuron performed one membrane update this cycle
- spike  in  1  neuron spike output, sampled only when step=1
- window_len  in  WINDOW_W  steps per window; 0 means 2^WINDOW_W; latched at window start
- count_out  out  COUNT_W  spike count of last completed window
- count_valid  out  1  one-cycle pulse when count_out updates
- saturated  out  1  last completed window's count clipped at max
- busy  out  1  high while a window is in progress (state RUN)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; count_out=0, count_valid=0, saturated=0, busy=0; internal step/spike counters=0, latched length=0.
- States: IDLE, RUN.
  - IDLE -> RUN: on a cycle with enable=1 and clear=0. That cycle latches window_len, zeroes both counters and drives busy=1 from the next cycle. A step in that same cycle is ignored.
  - RUN, step=1: step counter +1. If spike=1, spike counter +1, saturating at 2^COUNT_W-1, with an internal sat bit set.
  - RUN, last step (step counter reaches latched length, incl. the 0 => 2^WINDOW_W case):
    - count_out <= final count, including a spike on that same step.
    - saturated <= sat bit; count_valid=1 next cycle for exactly one cycle.
    - Counters reset and latched length reloads from window_len in the same cycle. Windows are back-to-back with no dead cycle, and the state stays RUN.
  - RUN, enable=0 or clear=1: abort to IDLE next cycle. No count_valid; count_out/saturated keep the previous window's values. clear takes priority over step completion in the same cycle.
- step=0 cycles: no state change; spike ignored.
- Latency: count_valid asserted the cycle after the final step strobe.
- window_len changes mid-window have no effect until the next window start.
- count_out holds between pulses; never glitches outside a window end.

Optional Feature:
- Macro ISI_EN.
- Defined: adds output isi_out [WINDOW_W-1:0] and isi_valid (1).
  - A step counter since the previous spike runs across window boundaries and saturates at all-ones.
  - On each spike step after the first since IDLE: isi_out <= interval in steps, and isi_valid pulses next cycle.
  - The first spike only starts timing. Reset/IDLE clears the interval tracker, isi_out=0 and isi_valid=0.
- Undefined: ports absent; no extra logic.

Decomposition:
- Shared package (lif_pkg): state enum {IDLE, RUN}; default widths WINDOW_W_DEF=8, COUNT_W_DEF=8.
- One natural sub-module: sat_counter (parameterised width, inc/clear, saturate flag), used for the spike counter and, under ISI_EN, the interval counter.
- Window FSM stays in the top.

Test Plan:
- Reset mid-RUN with count in progress -> all outputs 0 immediately (async), state IDLE, no count_valid after release.
- window_len=4, enable=1, steps with spikes 1,0,1,1 -> count_valid one cycle after 4th step, count_out=3, saturated=0; next window starts without gap.
- COUNT_W=8, window_len=0 (256 steps), spike=1 on every step -> count_out=255, saturated=1.
- window_len=5, deassert enable after 3 steps -> busy falls, no count_valid, count_out holds previous value; clear=1 on the final step likewise suppresses the result.
- Change window_len 4->2 mid-window -> current window completes at 4 steps, following window at 2 steps.
- ISI_EN: spikes at steps 2, 7, 10 (windows of 4) -> isi_valid pulses with isi_out=5 then 3; no pulse on the first spike.
